// File: rtl/ram_host_pkg.sv
// Shared types and constants for the host-side sequencer of the 4096x16 RAM.
// Covers the FSM state encoding, the default bus widths and the RAM direction encoding.
package ram_host_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_host_ctrl_if.sv
// Request/response channels between upstream logic and ram_host_ctrl.
// The master modport is the requester side; the slave modport is the sequencer side.
interface ram_host_ctrl_if #(
   parameter int ADDR_W = ram_host_pkg::ADDR_W,
   parameter int DATA_W = ram_host_pkg::DATA_W
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_is_read;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_is_read, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_is_read, rsp_rdata
   );

endinterface

// File: rtl/ram_host_ctrl.sv
// Single-outstanding-transaction sequencer that owns the RAM addr/rw/data pins.
// It holds each write for WR_CYC edges, samples read data RD_LAT edges after the address is presented, and returns a completion.
module ram_host_ctrl #(
   parameter int ADDR_W = ram_host_pkg::ADDR_W,
   parameter int DATA_W = ram_host_pkg::DATA_W,
   parameter int WR_CYC = 3,
   parameter int RD_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_host_ctrl_if.slave    host,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rw,
   inout  wire  [DATA_W-1:0] mem_data
);

   import ram_host_pkg::*;

   state_t            r_state;
   state_t            w_state_nx;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic              r_rw;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wbuf;
   logic [DATA_W-1:0] r_rdata;
   logic              r_is_read;
   logic              w_accept;
   logic              w_cnt_done;

   assign w_accept   = host.req_valid && (r_state == IDLE);
   assign w_cnt_done = (r_cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      // NOTE: default assigned first so every path drives w_state_nx and no latch is inferred.
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (host.req_valid) w_state_nx = host.req_we ? WRITE : READ;
         WRITE:   if (w_cnt_done)     w_state_nx = RESP;
         READ:    if (w_cnt_done)     w_state_nx = RESP;
         RESP:    if (host.rsp_ready) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // The rw pin is registered from the next state, so it rises on acceptance and falls on the edge that leaves WRITE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_rw      <= RW_READ;
         r_addr    <= '0;
         r_wbuf    <= '0;
         r_rdata   <= '0;
         r_is_read <= 1'b0;
      end else begin
         r_rw <= (w_state_nx == WRITE) ? RW_WRITE : RW_READ;
         if (w_accept) begin
            r_addr <= host.req_addr;
            r_wbuf <= host.req_wdata;
            r_we   <= host.req_we;
            r_cnt  <= host.req_we ? CNT_W'(WR_CYC) : CNT_W'(RD_LAT);
         end else if (r_state == WRITE || r_state == READ) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_cnt_done) begin
               r_is_read <= !r_we;
               r_rdata   <= r_we ? '0 : mem_data;
            end
         end
      end
   end

   assign mem_data = (r_rw == RW_WRITE) ? r_wbuf : 'z;

   assign mem_addr         = r_addr;
   assign mem_rw           = r_rw;
   assign host.req_ready   = (r_state == IDLE);
   assign host.rsp_valid   = (r_state == RESP);
   assign host.rsp_is_read = r_is_read;
   assign host.rsp_rdata   = r_rdata;

endmodule

// File: tb/tb_ram_host_ctrl.sv
// Directed bench for ram_host_ctrl with a behavioural 4096x16 RAM on the tri-state bus.
// It checks cycle timing, read-back data, response back-pressure and asynchronous reset mid-write.
module tb_ram_host_ctrl;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;
   localparam int WR_CYC = 3;
   localparam int RD_LAT = 3;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rw;
   wire  [DATA_W-1:0] mem_data;

   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

   int n_tests;
   int n_fail;

   ram_host_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host ();

   ram_host_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .WR_CYC (WR_CYC),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .host     (host),
      .mem_addr (mem_addr),
      .mem_rw   (mem_rw),
      .mem_data (mem_data)
   );

   // RAM model: drives the bus whenever rw selects read, latches on every write edge.
   assign mem_data = mem_rw ? 'z : ram[mem_addr];

   always @(posedge clk) begin
      if (mem_rw) ram[mem_addr] <= mem_data;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_txn(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd,
                          input int hold);
      int k;
      int lat;
      @(negedge clk);
      host.rsp_ready = (hold == 0);
      host.req_valid = 1'b1;
      host.req_we    = we;
      host.req_addr  = a;
      host.req_wdata = d;
      k = 0;
      while (!host.req_ready && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("accept_wait", 32'(k < 40), 32'd1);
      @(posedge clk);
      #1;
      host.req_valid = 1'b0;
      host.req_wdata = 16'hDEAD;
      check("mem_addr", 32'(mem_addr), 32'(a));
      check("req_ready_busy", 32'(host.req_ready), 32'd0);
      lat = 0;
      while (!host.rsp_valid && lat < 40) begin
         check("mem_rw_during", 32'(mem_rw), 32'(we));
         @(posedge clk);
         #1;
         lat++;
      end
      check("rsp_latency", 32'(lat), we ? 32'(WR_CYC) : 32'(RD_LAT));
      check("mem_rw_after", 32'(mem_rw), 32'd0);
      check("rsp_is_read", 32'(host.rsp_is_read), 32'(!we));
      check("rsp_rdata", 32'(host.rsp_rdata), we ? 32'd0 : 32'(exp_rd));
      if (hold > 0) begin
         host.req_valid = 1'b1;
         host.req_we    = 1'b0;
         host.req_addr  = 12'h777;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_rsp_valid", 32'(host.rsp_valid), 32'd1);
            check("hold_rsp_rdata", 32'(host.rsp_rdata), 32'(exp_rd));
            check("hold_req_ready", 32'(host.req_ready), 32'd0);
            check("hold_mem_addr", 32'(mem_addr), 32'(a));
         end
         host.req_valid = 1'b0;
         host.rsp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check("req_ready_after", 32'(host.req_ready), 32'd1);
      check("rsp_valid_after", 32'(host.rsp_valid), 32'd0);
      if (we) check("ram_word", 32'(ram[a]), 32'(d));
   endtask

   initial begin
      n_tests        = 0;
      n_fail         = 0;
      rst_n          = 1'b0;
      host.req_valid = 1'b0;
      host.req_we    = 1'b0;
      host.req_addr  = '0;
      host.req_wdata = '0;
      host.rsp_ready = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_req_ready", 32'(host.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(host.rsp_valid), 32'd0);
      check("rst_rsp_is_read", 32'(host.rsp_is_read), 32'd0);
      check("rst_rsp_rdata", 32'(host.rsp_rdata), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_rw", 32'(mem_rw), 32'd0);
      rst_n = 1'b1;

      run_txn(1'b1, 12'h005, 16'h0ABC, 16'h0000, 0);
      run_txn(1'b0, 12'h005, 16'h0000, 16'h0ABC, 0);

      run_txn(1'b1, 12'h3FF, 16'h1111, 16'h0000, 0);
      run_txn(1'b1, 12'h400, 16'h2222, 16'h0000, 0);
      run_txn(1'b0, 12'h3FF, 16'h0000, 16'h1111, 0);
      run_txn(1'b0, 12'h400, 16'h0000, 16'h2222, 0);

      run_txn(1'b0, 12'h005, 16'h0000, 16'h0ABC, 5);

      run_txn(1'b1, 12'h000, 16'h1357, 16'h0000, 0);
      run_txn(1'b0, 12'h000, 16'h0000, 16'h1357, 0);
      run_txn(1'b1, 12'h000, 16'hFFFF, 16'h0000, 0);
      run_txn(1'b0, 12'h000, 16'h0000, 16'hFFFF, 0);

      // Reset pulse in the second WRITE cycle must clear outputs without waiting for an edge.
      @(negedge clk);
      host.req_valid = 1'b1;
      host.req_we    = 1'b1;
      host.req_addr  = 12'h020;
      host.req_wdata = 16'h5555;
      @(posedge clk);
      #1;
      host.req_valid = 1'b0;
      check("mid_wr_mem_rw", 32'(mem_rw), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_mem_rw", 32'(mem_rw), 32'd0);
      check("arst_rsp_valid", 32'(host.rsp_valid), 32'd0);
      check("arst_req_ready", 32'(host.req_ready), 32'd1);
      check("arst_mem_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(1'b1, 12'h020, 16'h6666, 16'h0000, 0);
      run_txn(1'b0, 12'h020, 16'h0000, 16'h6666, 0);

      run_txn(1'b1, 12'hFFF, 16'hA5A5, 16'h0000, 0);
      run_txn(1'b0, 12'hFFF, 16'h0000, 16'hA5A5, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_host_ctrl.md
# ram_host_ctrl

Host-side sequencer sitting directly upstream of the 4096×16 RAM array; it is the only master of that RAM's `addr`, `rw` and bidirectional `data` bus. It accepts single-word read/write requests on a valid/ready interface and holds address, direction and write data for the RAM's required number of cycles. It samples read data after a fixed latency and returns a completion on a valid/ready response channel, so upstream logic never touches the tri-state bus.

## Interface
- `ADDR_W`, default 12: RAM word-address width.
- `DATA_W`, default 16: RAM word width.
- `WR_CYC`, default 3: clock edges that address, data and `rw=1` are held for one write; legal range 1..15.
- `RD_LAT`, default 3: clock edges after the address is presented at which read data is sampled; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data; ignored for reads.
- `rsp_valid`  out  1  completion present.
- `rsp_ready`  in  1  consumer takes the completion.
- `rsp_is_read`  out  1  completion belongs to a read.
- `rsp_rdata`  out  DATA_W  read data; 0 for write completions.
- `mem_addr`  out  ADDR_W  to RAM `addr`.
- `mem_rw`  out  1  to RAM `rw`: 1 = write, 0 = read.
- `mem_data`  inout  DATA_W  to RAM `data`; this block drives it only while `mem_rw`=1, otherwise it presents high-Z.

## Operation
- State machine: IDLE, WRITE, READ, RESP.
- IDLE:
  - `req_ready`=1 and `mem_rw`=0.
  - On `req_valid && req_ready`, register `req_addr` into `mem_addr`, `req_wdata` into the write buffer, and `req_we` into a flag.
  - Load the wait counter with WR_CYC or RD_LAT and go to WRITE or READ.
- WRITE:
  - `mem_rw`=1 and `mem_data` = write buffer.
  - The counter decrements each edge.
  - On the edge where the counter reaches 0, go to RESP with `rsp_is_read`=0 and `rsp_rdata`=0.
  - `mem_rw` returns to 0 together with that transition.
- READ:
  - `mem_rw`=0 and `mem_data` is high-Z.
  - On the edge where the counter reaches 0, capture `mem_data` into `rsp_rdata`, set `rsp_is_read`=1, and go to RESP.
- RESP:
  - `rsp_valid`=1.
  - `rsp_rdata` and `rsp_is_read` stay stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `req_ready` = (state == IDLE), decoded from the registered state. No combinational path from `req_valid` to `req_ready`.
- `mem_addr` holds its last value outside transactions; it changes only on acceptance.
- One transaction is in flight at a time; there is no queueing.
- The mandatory IDLE cycle between transactions also gives the bus a turnaround gap.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_is_read`=0, `rsp_rdata`=0, `mem_addr`=0, `mem_rw`=0, `mem_data` high-Z.
- Acceptance at edge E0 puts the new `mem_addr` and `mem_rw` on the RAM pins right after E0.
- Write: `mem_rw`=1 from E0 through E(WR_CYC). `rsp_valid` rises after E(WR_CYC).
- Read: `mem_data` is sampled at E(RD_LAT). `rsp_valid` rises after that same edge.
- Completion handshake: if `rsp_ready` is already 1, the response handshake occurs at E(n+1) and `req_ready` is 1 after E(n+1).
- Minimum period per transaction: WR_CYC+2 edges for a write, RD_LAT+2 for a read.
- `req_valid` asserted in any state other than IDLE is ignored; the requester must hold it.
- A new request is never accepted in the same cycle as a response handshake.
- Reset asserted mid-transaction:
  - All outputs go to their reset values immediately (asynchronously): `mem_rw`=0, bus released, `rsp_valid` dropped.
  - The transaction is discarded. A partially completed write leaves the RAM word undefined.
- Counter width is 4 bits, so WR_CYC and RD_LAT must lie in 1..15; a value of 0 is illegal.

## Structure
- Package `ram_host_pkg`:
  - state enum (IDLE, WRITE, READ, RESP);
  - constants ADDR_W=12 and DATA_W=16;
  - the RAM direction encoding RW_WRITE=1, RW_READ=0.
- Single module with no sub-module.
- Implement the tri-state driver as one continuous assignment gated by the registered `mem_rw`.

## Test plan
- Write 0x0ABC to 0x005, then read 0x005 → `rsp_is_read`=1, `rsp_rdata`=0x0ABC; `rsp_valid` rises 3 edges after the read is accepted (RD_LAT=3).
- Write 0x1111 to 0x3FF and 0x2222 to 0x400 (bank boundary), read both back → 0x1111, 0x2222; no cross-bank corruption.
- Hold `rsp_ready`=0 for 5 cycles after a read completion → `rsp_valid` and `rsp_rdata` stay stable and `req_ready` stays 0 throughout.
- Back-to-back read of 0x000 then write of 0xFFFF to 0x000 → `mem_data` is never driven while `mem_rw`=0; a subsequent read returns 0xFFFF.
- Pulse `rst_n` low in the second WRITE cycle → `mem_rw`=0, `rsp_valid`=0 and `req_ready`=1 immediately; the next transaction completes normally.
- Write 0xA5A5 to 0xFFF, then read 0xFFF → 0xA5A5 (top address, addr[11:10]=11).
